// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and grant IDs.
// No logic; latency and backpressure are properties of mem_port_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_MA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and cache-controller handshake bundle for mem_port_arbiter.
// master = arbiter side; slave = the pipeline stages and cache controller around it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              ma_read;
   logic              ma_write;
   logic [ADDR_W-1:0] ma_addr;
   logic [DATA_W-1:0] ma_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              cc_enable;
   logic              cc_read;
   logic              cc_write;
   logic [ADDR_W-1:0] cc_addr;
   logic [DATA_W-1:0] cc_wdata;
   logic              if_done;
   logic              ma_done;
   logic [DATA_W-1:0] rdata;
   logic              if_stall;
   logic              ma_stall;

   modport master (
      input  if_req, if_addr, ma_read, ma_write, ma_addr, ma_wdata, mem_ready, mem_rdata,
      output cc_enable, cc_read, cc_write, cc_addr, cc_wdata, if_done, ma_done, rdata,
             if_stall, ma_stall
   );

   modport slave (
      output if_req, if_addr, ma_read, ma_write, ma_addr, ma_wdata, mem_ready, mem_rdata,
      input  cc_enable, cc_read, cc_write, cc_addr, cc_wdata, if_done, ma_done, rdata,
             if_stall, ma_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between IF and MA; grant -> cc_enable next edge, done pulses on the mem_ready edge, 3-cycle min grant spacing.
// Requesters hold their request and stall until done; MA wins ties unless ARB_ROUND_ROBIN_EN alternates them.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.master  bus
);

   state_t            state;
   logic              gnt;
   logic              ma_pend;
   logic              win;
   logic              cc_enable_q;
   logic              cc_read_q;
   logic              cc_write_q;
   logic [ADDR_W-1:0] cc_addr_q;
   logic [DATA_W-1:0] cc_wdata_q;
   logic              if_done_q;
   logic              ma_done_q;
   logic [DATA_W-1:0] rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic              last_grant;
`endif

   assign ma_pend = bus.ma_read | bus.ma_write;

   always_comb begin
      win = ma_pend ? GNT_MA : GNT_IF;
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.if_req && ma_pend)
         win = (last_grant == GNT_MA) ? GNT_IF : GNT_MA;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         gnt         <= GNT_MA;
         cc_enable_q <= 1'b0;
         cc_read_q   <= 1'b0;
         cc_write_q  <= 1'b0;
         cc_addr_q   <= '0;
         cc_wdata_q  <= '0;
         if_done_q   <= 1'b0;
         ma_done_q   <= 1'b0;
         rdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant  <= GNT_MA;
`endif
      end else begin
         if_done_q <= 1'b0;
         ma_done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.if_req || ma_pend) begin
                  gnt         <= win;
                  cc_enable_q <= 1'b1;
                  state       <= ST_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant  <= win;
`endif
                  if (win == GNT_MA) begin
                     // A simultaneous read+write strobe is served as a write.
                     cc_addr_q  <= bus.ma_addr;
                     cc_wdata_q <= bus.ma_wdata;
                     cc_write_q <= bus.ma_write;
                     cc_read_q  <= ~bus.ma_write;
                  end else begin
                     cc_addr_q  <= bus.if_addr;
                     cc_write_q <= 1'b0;
                     cc_read_q  <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (bus.mem_ready) begin
                  if (cc_read_q)
                     rdata_q <= bus.mem_rdata;
                  if (gnt == GNT_MA)
                     ma_done_q <= 1'b1;
                  else
                     if_done_q <= 1'b1;
                  cc_enable_q <= 1'b0;
                  state       <= ST_RELEASE;
               end
            end
            ST_RELEASE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cc_enable = cc_enable_q;
   assign bus.cc_read   = cc_read_q;
   assign bus.cc_write  = cc_write_q;
   assign bus.cc_addr   = cc_addr_q;
   assign bus.cc_wdata  = cc_wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.ma_done   = ma_done_q;
   assign bus.rdata     = rdata_q;
   assign bus.if_stall  = bus.if_req & ~if_done_q;
   assign bus.ma_stall  = ma_pend & ~ma_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled 1 time unit after each rising edge.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.ma_read   = 1'b0;
      bus.ma_write  = 1'b0;
      bus.ma_addr   = '0;
      bus.ma_wdata  = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.cc_enable !== 1'b0) begin errs++; $display("FAIL rst_cc_enable: got %b expected 0", bus.cc_enable); end
      checks++; if (bus.cc_read !== 1'b0) begin errs++; $display("FAIL rst_cc_read: got %b expected 0", bus.cc_read); end
      checks++; if (bus.cc_write !== 1'b0) begin errs++; $display("FAIL rst_cc_write: got %b expected 0", bus.cc_write); end
      checks++; if (bus.cc_addr !== 32'h0) begin errs++; $display("FAIL rst_cc_addr: got %h expected 0", bus.cc_addr); end
      checks++; if (bus.cc_wdata !== 32'h0) begin errs++; $display("FAIL rst_cc_wdata: got %h expected 0", bus.cc_wdata); end
      checks++; if (bus.rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
      checks++; if ({bus.if_done, bus.ma_done} !== 2'b00) begin errs++; $display("FAIL rst_done: got %b expected 00", {bus.if_done, bus.ma_done}); end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      checks++; if (bus.cc_enable !== 1'b0) begin errs++; $display("FAIL idle_no_req: got %b expected 0", bus.cc_enable); end
   endtask

   task automatic test_ma_write();
      bus.ma_write = 1'b1;
      bus.ma_addr  = 32'h40;
      bus.ma_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (bus.ma_stall !== 1'b1) begin errs++; $display("FAIL wr_stall_pending: got %b expected 1", bus.ma_stall); end
      tick();
      checks++; if (bus.cc_enable !== 1'b1) begin errs++; $display("FAIL wr_enable: got %b expected 1", bus.cc_enable); end
      checks++; if ({bus.cc_write, bus.cc_read} !== 2'b10) begin errs++; $display("FAIL wr_strobes: got %b expected 10", {bus.cc_write, bus.cc_read}); end
      checks++; if (bus.cc_addr !== 32'h40) begin errs++; $display("FAIL wr_addr: got %h expected 00000040", bus.cc_addr); end
      checks++; if (bus.cc_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_wdata: got %h expected deadbeef", bus.cc_wdata); end
      repeat (3) tick();
      checks++; if ({bus.cc_enable, bus.ma_done} !== 2'b10) begin errs++; $display("FAIL wr_busy_hold: got %b expected 10", {bus.cc_enable, bus.ma_done}); end
      bus.mem_ready = 1'b1;
      tick();
      checks++; if (bus.ma_done !== 1'b1) begin errs++; $display("FAIL wr_done: got %b expected 1", bus.ma_done); end
      checks++; if (bus.cc_enable !== 1'b0) begin errs++; $display("FAIL wr_enable_drop: got %b expected 0", bus.cc_enable); end
      checks++; if (bus.ma_stall !== 1'b0) begin errs++; $display("FAIL wr_stall_at_done: got %b expected 0", bus.ma_stall); end
      bus.mem_ready = 1'b0;
      bus.ma_write  = 1'b0;
      tick();
      checks++; if ({bus.ma_done, bus.ma_stall} !== 2'b00) begin errs++; $display("FAIL wr_done_pulse: got %b expected 00", {bus.ma_done, bus.ma_stall}); end
      tick();
   endtask

   task automatic test_if_read();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      tick();
      checks++; if ({bus.cc_enable, bus.cc_read, bus.cc_write} !== 3'b110) begin errs++; $display("FAIL rd_strobes: got %b expected 110", {bus.cc_enable, bus.cc_read, bus.cc_write}); end
      checks++; if (bus.cc_addr !== 32'h100) begin errs++; $display("FAIL rd_addr: got %h expected 00000100", bus.cc_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h12345678;
      tick();
      checks++; if ({bus.if_done, bus.ma_done, bus.if_stall} !== 3'b100) begin errs++; $display("FAIL rd_done: got %b expected 100", {bus.if_done, bus.ma_done, bus.if_stall}); end
      checks++; if (bus.rdata !== 32'h12345678) begin errs++; $display("FAIL rd_rdata: got %h expected 12345678", bus.rdata); end
      clear_inputs();
      tick();
      checks++; if ({bus.if_done, bus.cc_write} !== 2'b00) begin errs++; $display("FAIL rd_after: got %b expected 00", {bus.if_done, bus.cc_write}); end
      checks++; if (bus.rdata !== 32'h12345678) begin errs++; $display("FAIL rd_rdata_hold: got %h expected 12345678", bus.rdata); end
      tick();
   endtask

   task automatic test_contention();
      logic exp_if;
      do_reset();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h200;
      bus.ma_read = 1'b1;
      bus.ma_addr = 32'h300;
`ifndef ARB_ROUND_ROBIN_EN
      exp_if = 1'b0;
      tick();
      checks++; if (bus.cc_addr !== 32'h300) begin errs++; $display("FAIL fix_first_ma: got %h expected 00000300", bus.cc_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hAAAA0001;
      tick();
      checks++; if ({bus.ma_done, bus.if_done, bus.if_stall, bus.cc_enable} !== 4'b1010) begin errs++; $display("FAIL fix_ma_done: got %b expected 1010", {bus.ma_done, bus.if_done, bus.if_stall, bus.cc_enable}); end
      bus.ma_read   = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      checks++; if (bus.cc_enable !== 1'b0) begin errs++; $display("FAIL fix_release_gap: got %b expected 0", bus.cc_enable); end
      tick();
      checks++; if ({bus.cc_enable, bus.cc_addr} !== {1'b1, 32'h200}) begin errs++; $display("FAIL fix_then_if: got %b/%h expected 1/00000200", bus.cc_enable, bus.cc_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hBBBB0002;
      tick();
      checks++; if ({bus.if_done, bus.rdata} !== {1'b1, 32'hBBBB0002}) begin errs++; $display("FAIL fix_if_done: got %b/%h expected 1/bbbb0002", bus.if_done, bus.rdata); end
`else
      exp_if = 1'b1;
      for (int r = 0; r < 4; r++) begin
         tick();
         checks++; if (bus.cc_addr !== (exp_if ? 32'h200 : 32'h300)) begin errs++; $display("FAIL rr_winner_%0d: got %h expected %h", r, bus.cc_addr, exp_if ? 32'h200 : 32'h300); end
         bus.mem_ready = 1'b1;
         tick();
         checks++; if ({bus.if_done, bus.ma_done} !== {exp_if, ~exp_if}) begin errs++; $display("FAIL rr_done_%0d: got %b expected %b", r, {bus.if_done, bus.ma_done}, {exp_if, ~exp_if}); end
         bus.mem_ready = 1'b0;
         if (exp_if) bus.if_req = 1'b0; else bus.ma_read = 1'b0;
         tick();
         bus.if_req  = 1'b1;
         bus.ma_read = 1'b1;
         exp_if = ~exp_if;
      end
`endif
      clear_inputs();
      repeat (2) tick();
   endtask

   task automatic test_spurious_ready();
      bus.mem_ready = 1'b1;
      tick();
      checks++; if ({bus.cc_enable, bus.if_done, bus.ma_done} !== 3'b000) begin errs++; $display("FAIL spur_idle: got %b expected 000", {bus.cc_enable, bus.if_done, bus.ma_done}); end
      bus.mem_ready = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h104;
      tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h55;
      tick();
      checks++; if (bus.if_done !== 1'b1) begin errs++; $display("FAIL spur_setup_done: got %b expected 1", bus.if_done); end
      bus.if_req    = 1'b0;
      bus.mem_rdata = 32'h66;
      tick();
      checks++; if ({bus.cc_enable, bus.if_done, bus.rdata} !== {2'b00, 32'h55}) begin errs++; $display("FAIL spur_release: got %b%b/%h expected 00/00000055", bus.cc_enable, bus.if_done, bus.rdata); end
      tick();
      checks++; if ({bus.cc_enable, bus.if_done, bus.ma_done} !== 3'b000) begin errs++; $display("FAIL spur_idle2: got %b expected 000", {bus.cc_enable, bus.if_done, bus.ma_done}); end
      bus.mem_ready = 1'b0;
      bus.ma_read   = 1'b1;
      bus.ma_addr   = 32'h108;
      tick();
      checks++; if ({bus.cc_enable, bus.cc_addr} !== {1'b1, 32'h108}) begin errs++; $display("FAIL spur_regrant: got %b/%h expected 1/00000108", bus.cc_enable, bus.cc_addr); end
      bus.mem_ready = 1'b1;
      tick();
      clear_inputs();
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_busy();
      bus.ma_write = 1'b1;
      bus.ma_addr  = 32'h40;
      bus.ma_wdata = 32'h1111;
      tick();
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.cc_enable, bus.ma_done, bus.cc_addr} !== {2'b00, 32'h0}) begin errs++; $display("FAIL rstb_abort: got %b%b/%h expected 00/00000000", bus.cc_enable, bus.ma_done, bus.cc_addr); end
      tick();
      checks++; if (bus.ma_done !== 1'b0) begin errs++; $display("FAIL rstb_no_done: got %b expected 0", bus.ma_done); end
      rst_n = 1'b1;
      tick();
      checks++; if ({bus.cc_enable, bus.cc_write, bus.cc_addr} !== {2'b11, 32'h40}) begin errs++; $display("FAIL rstb_regrant: got %b%b/%h expected 11/00000040", bus.cc_enable, bus.cc_write, bus.cc_addr); end
      bus.mem_ready = 1'b1;
      tick();
      checks++; if (bus.ma_done !== 1'b1) begin errs++; $display("FAIL rstb_done: got %b expected 1", bus.ma_done); end
      clear_inputs();
      repeat (2) tick();
   endtask

   task automatic test_input_churn();
      bus.ma_read = 1'b1;
      bus.ma_addr = 32'h40;
      tick();
      bus.ma_addr = 32'h80;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (bus.cc_addr !== 32'h40) begin errs++; $display("FAIL churn_addr_%0d: got %h expected 00000040", i, bus.cc_addr); end
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h77;
      tick();
      checks++; if ({bus.ma_done, bus.cc_addr, bus.rdata} !== {1'b1, 32'h40, 32'h77}) begin errs++; $display("FAIL churn_done: got %b/%h/%h expected 1/00000040/00000077", bus.ma_done, bus.cc_addr, bus.rdata); end
      clear_inputs();
      repeat (2) tick();
   endtask

   task automatic test_read_write_both();
      bus.ma_read  = 1'b1;
      bus.ma_write = 1'b1;
      bus.ma_addr  = 32'hC0;
      bus.ma_wdata = 32'hCAFE;
      tick();
      checks++; if ({bus.cc_write, bus.cc_read} !== 2'b10) begin errs++; $display("FAIL rw_as_write: got %b expected 10", {bus.cc_write, bus.cc_read}); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h99;
      tick();
      checks++; if ({bus.ma_done, bus.rdata} !== {1'b1, 32'h77}) begin errs++; $display("FAIL rw_no_capture: got %b/%h expected 1/00000077", bus.ma_done, bus.rdata); end
      clear_inputs();
      repeat (2) tick();
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst_n  = 1'b0;
      clear_inputs();
      test_reset();
      test_ma_write();
      test_if_read();
      test_contention();
      test_spurious_ready();
      test_reset_mid_busy();
      test_input_churn();
      test_read_write_both();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
